// File: rtl/alu_pkg.sv
// Shared types and constants for the serial add/subtract controller.
package alu_pkg;

    // Controller states: waiting for operands, shifting bits, holding result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Encoding of the sub input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// 1-bit full adder built from two half adders and an OR for the carry.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s1;
    logic c1;
    logic c2;

    ha_cell u_ha0 (
        .a (a),
        .b (b),
        .s (s1),
        .c (c1)
    );

    ha_cell u_ha1 (
        .a (s1),
        .b (ci),
        .s (s),
        .c (c2)
    );

    assign co = c1 | c2;

endmodule

// File: rtl/ha_cell.sv
// 1-bit half adder.
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit add/subtract: one full-adder cell is reused LSB first,
// one bit per clock, with operands and result held in shift registers.
//
// Handshake: an operation is accepted on a rising edge where in_valid and
// in_ready are both high (in_ready is high only in IDLE); a result is handed
// off on a rising edge where out_valid and out_ready are both high, and
// sum/cout/ovf stay stable while out_valid is high and out_ready is low.
module serial_adder_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output state_t           state_dbg
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last_bit;

    // The single shared adder slice always looks at the current LSBs.
    fa_cell u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign accept   = in_valid && in_ready;
    assign last_bit = (state == RUN) && (cnt == LAST_BIT);

    // Result register shifted right with the new sum bit entering at the MSB.
    always_comb begin
        res_nxt            = res_sr >> 1;
        res_nxt[WIDTH-1]   = fa_s;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (cnt == LAST_BIT) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand/result shift registers, carry, bit counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1, so the carry seeds the "+1".
            a_sr   <= a;
            b_sr   <= (sub == OP_SUB) ? ~b : b;
            carry  <= (sub == OP_SUB) ? 1'b1 : cin;
            res_sr <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_nxt;
            carry  <= fa_co;
            cnt    <= cnt + CNT_W'(1);
            if (last_bit) begin
                // carry still holds the carry into the MSB slice here.
                sum_q  <= res_nxt;
                cout_q <= fa_co;
                ovf_q  <= carry ^ fa_co;
            end
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized bench for serial_adder_ctrl against an arithmetic reference model.
module tb_serial_adder_ctrl;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    state_t       state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [W+1:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .state_dbg (state_dbg)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
        longint ua, ub, sa, sb, ur, sr, smax, smin;
        logic [W-1:0] s;
        logic co, ov;
        ua   = longint'(ma);
        ub   = longint'(mb);
        sa   = ma[W-1] ? ua - (longint'(1) << W) : ua;
        sb   = mb[W-1] ? ub - (longint'(1) << W) : ub;
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        if (msub) begin
            ur = ua - ub;
            co = (ua >= ub);
            sr = sa - sb;
        end else begin
            ur = ua + ub + longint'(mcin);
            co = (ur >= (longint'(1) << W));
            sr = sa + sb + longint'(mcin);
        end
        s  = W'(ur);
        ov = (sr > smax) || (sr < smin);
        return {ov, co, s};
    endfunction

    // Drive one operation through accept, run, backpressure and handoff.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tcin, input logic tsub, input int hold);
        logic [W+1:0] exp_v;
        int  cyc;
        bit  acc;
        a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) acc = 1'b1;
            @(posedge clk); #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        exp_q.push_back(model(ta, tb_v, tcin, tsub));

        // Busy phase: scramble inputs, they must have no effect.
        cyc = 0;
        while (!out_valid && cyc < 4 * W + 8) begin
            check("busy_in_ready", 32'(in_ready), 32'd0);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        check("latency", 32'(cyc), 32'(W));

        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("result", 32'({ovf, cout, sum}), 32'(exp_v));

        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_result", 32'({ovf, cout, sum}), 32'(exp_v));
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_valid", 32'(out_valid), 32'd0);
        check("idle_retain", 32'({ovf, cout, sum}), 32'(exp_v));
    endtask

    // Stimulus sequence.
    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'({ovf, cout, sum}), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));

        do_op(8'h0F, 8'h01, 1'b0, OP_ADD, 0);
        do_op(8'hFF, 8'h01, 1'b0, OP_ADD, 1);
        do_op(8'h7F, 8'h01, 1'b0, OP_ADD, 0);
        do_op(8'h05, 8'h07, 1'b0, OP_SUB, 0);
        do_op(8'h80, 8'h01, 1'b0, OP_SUB, 0);
        do_op(8'hFF, 8'hFF, 1'b1, OP_ADD, 0);
        do_op(8'h00, 8'h00, 1'b1, OP_SUB, 0);
        do_op(8'h3C, 8'hA5, 1'b1, OP_ADD, 20);

        // Reset in the third RUN cycle discards the operation.
        a = 8'h33; b = 8'h44; cin = 1'b0; sub = OP_ADD; in_valid = 1'b1;
        check("pre_abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_state", 32'(state_dbg), 32'(IDLE));
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", 32'({ovf, cout, sum}), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("abort_no_pulse", 32'(out_valid), 32'd0);
        end
        do_op(8'h01, 8'h01, 1'b0, OP_ADD, 0);

        // Random operations.
        for (int n = 0; n < 40; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 4));
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
